williams2_rom_loader: RTL and testbench

//  Download-to-core bridge between hps_io ioctl stream and williams2 dn_* ROM write port.

---
 rtl/williams2_rom_loader.sv | 213 +++++++++++++++++++++
 tb/tb_williams2_rom_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/williams2_rom_loader.sv
// ---------------------------------------------------------------------------
// williams2_rom_loader
//
// Bridge from the hps_io ioctl download stream to the williams2 dn_* ROM
// write port. Only downloads with ioctl_index == ROM_INDEX are forwarded;
// addresses at or beyond ROM_SIZE are dropped and flagged. Each accepted byte
// is presented on dn_* exactly one clk_sys cycle after its ioctl_wr strobe.
// The game core is held in reset during the download and for HOLD_CYCLES
// cycles afterwards. Short or overflowing images raise rom_err.
//
// Optional feature macro: WILLIAMS2_ROM_CHECKSUM_EN
//   defined     -> checksum is a running 16-bit additive sum of accepted bytes
//   not defined -> checksum is tied to 16'h0000
//
// Ports
//   clk_sys         in   1       system clock (shared with hps_io)
//   reset_n         in   1       asynchronous active-low reset
//   ioctl_download  in   1       download in progress
//   ioctl_wr        in   1       one-cycle byte write strobe
//   ioctl_addr      in   25      byte address
//   ioctl_dout      in   8       byte data
//   ioctl_index     in   16      image index
//   dn_addr         out  ADDR_W  ROM write address
//   dn_data         out  8       ROM write data
//   dn_wr           out  1       one-cycle ROM write strobe
//   core_reset      out  1       active-high reset to the game core
//   rom_ready       out  1       complete download finished, core released
//   rom_err         out  1       size mismatch / out-of-range write seen
//   byte_count      out  19      bytes accepted in current/last download
//   checksum        out  16      additive checksum of accepted bytes
// ---------------------------------------------------------------------------
module williams2_rom_loader #(
    parameter logic [15:0] ROM_INDEX   = 16'd0,
    parameter logic [18:0] ROM_SIZE    = 19'h40000,
    parameter int          ADDR_W      = 18,
    parameter int          HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [15:0]       ioctl_index,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic              core_reset,
    output logic              rom_ready,
    output logic              rom_err,
    output logic [18:0]       byte_count,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

    state_t            state_q;
    logic [15:0]       hold_q;
    logic              match_q;
    logic              core_reset_q;
    logic              rom_ready_q;
    logic              rom_err_q;
    logic              rom_err_d;
    logic [18:0]       byte_count_q;
    logic [18:0]       byte_count_d;
    logic [ADDR_W-1:0] dn_addr_q;
    logic [7:0]        dn_data_q;
    logic              dn_wr_q;

    logic match;
    logic in_range;
    logic accept;
    logic out_of_range;
    logic load_entry;
    logic hold_done;

    // Range check uses the full 25-bit address so aliased high addresses
    // are never mistaken for legal ones.
    always_comb begin
        match        = ioctl_download && (ioctl_index == ROM_INDEX);
        in_range     = ioctl_addr < {6'd0, ROM_SIZE};
        accept       = match && ioctl_wr && in_range;
        out_of_range = match && ioctl_wr && !in_range;
        load_entry   = match && (state_q != LOAD);
        hold_done    = (state_q == HOLD) && !match && (hold_q == 16'd0);
    end

    // On LOAD entry the count restarts, including a byte accepted in that
    // same cycle. The count saturates instead of wrapping.
    always_comb begin
        byte_count_d = byte_count_q;
        if (load_entry) begin
            byte_count_d = accept ? 19'd1 : 19'd0;
        end else if (accept && (byte_count_q != 19'h7FFFF)) begin
            byte_count_d = byte_count_q + 19'd1;
        end
    end

    // Error flag is sticky between LOAD entries; the size check happens
    // on the HOLD -> DONE transition.
    always_comb begin
        rom_err_d = load_entry ? 1'b0 : rom_err_q;
        if (out_of_range) begin
            rom_err_d = 1'b1;
        end
        if (hold_done && (byte_count_q != ROM_SIZE)) begin
            rom_err_d = 1'b1;
        end
    end

    // Control FSM with registered core_reset / rom_ready.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hold_q       <= 16'd0;
            match_q      <= 1'b0;
            core_reset_q <= 1'b1;
            rom_ready_q  <= 1'b0;
            rom_err_q    <= 1'b0;
            byte_count_q <= 19'd0;
        end else begin
            match_q      <= match;
            rom_err_q    <= rom_err_d;
            byte_count_q <= byte_count_d;
            case (state_q)
                IDLE, DONE: begin
                    if (match) begin
                        state_q      <= LOAD;
                        core_reset_q <= 1'b1;
                        rom_ready_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!match && match_q) begin
                        state_q <= HOLD;
                        hold_q  <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (match) begin
                        state_q <= LOAD;
                    end else if (hold_q == 16'd0) begin
                        state_q      <= DONE;
                        core_reset_q <= 1'b0;
                        rom_ready_q  <= 1'b1;
                    end else begin
                        hold_q <= hold_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // One-stage write register; address/data hold between writes.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dn_addr_q <= '0;
            dn_data_q <= 8'd0;
            dn_wr_q   <= 1'b0;
        end else begin
            dn_wr_q <= accept;
            if (accept) begin
                dn_addr_q <= ioctl_addr[ADDR_W-1:0];
                dn_data_q <= ioctl_dout;
            end
        end
    end

`ifdef WILLIAMS2_ROM_CHECKSUM_EN
    logic [15:0] checksum_q;
    logic [15:0] checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (load_entry) begin
            checksum_d = accept ? {8'h00, ioctl_dout} : 16'h0000;
        end else if (accept) begin
            checksum_d = checksum_q + {8'h00, ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= 16'h0000;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign core_reset = core_reset_q;
    assign rom_ready  = rom_ready_q;
    assign rom_err    = rom_err_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_williams2_rom_loader.sv
// Directed testbench for williams2_rom_loader with a 16-byte image and a
// 4-cycle hold window. Expected values are hand-computed constants.
module tb_williams2_rom_loader;

    localparam int HOLD_CYC = 4;

`ifdef WILLIAMS2_ROM_CHECKSUM_EN
    localparam logic [15:0] SUM_FULL = 16'h0178;
    localparam logic [15:0] SUM_HALF = 16'h009C;
`else
    localparam logic [15:0] SUM_FULL = 16'h0000;
    localparam logic [15:0] SUM_HALF = 16'h0000;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic [15:0] ioctl_index = 16'd0;
    logic [17:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_reset;
    logic        rom_ready;
    logic        rom_err;
    logic [18:0] byte_count;
    logic [15:0] checksum;

    int checkCount = 0;
    int passCount = 0;
    int failCount = 0;

    williams2_rom_loader #(
        .ROM_INDEX   (16'd0),
        .ROM_SIZE    (19'd16),
        .ADDR_W      (18),
        .HOLD_CYCLES (HOLD_CYC)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .core_reset     (core_reset),
        .rom_ready      (rom_ready),
        .rom_err        (rom_err),
        .byte_count     (byte_count),
        .checksum       (checksum)
    );

    // 100 MHz-style free-running clock; timing is in cycles only.
    always #5 clk_sys = ~clk_sys;

    // Advance to just after the next rising edge so outputs are settled.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of ioctl inputs and step past the following edge.
    task automatic applyStimulus(input logic dl, input logic wr, input logic [24:0] addr,
                                 input logic [7:0] data, input logic [15:0] idx);
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_addr     = addr;
        ioctl_dout     = data;
        ioctl_index    = idx;
        tick();
    endtask

    // Stream addresses first..last with data 0x10+addr; only index 0 with
    // an in-range address should produce a dn_wr one cycle later.
    task automatic sendRange(input logic [15:0] idx, input int first, input int last);
        for (int a = first; a <= last; a++) begin
            logic expWr;
            expWr = (idx == 16'd0) && (a < 16);
            applyStimulus(1'b1, 1'b1, 25'(a), 8'(8'h10 + a), idx);
            checkOutput($sformatf("dn_wr idx%0d addr%0d", idx, a), dn_wr, expWr);
            if (expWr) begin
                checkOutput($sformatf("dn_addr addr%0d", a), dn_addr, a);
                checkOutput($sformatf("dn_data addr%0d", a), dn_data, 8'(8'h10 + a));
            end
        end
    endtask

    // Drop download and walk the hold window, checking its exact length.
    task automatic finishDownload();
        applyStimulus(1'b0, 1'b0, 25'd0, 8'd0, 16'd0);
        checkOutput("dn_wr after end", dn_wr, 0);
        checkOutput("core_reset in hold", core_reset, 1);
        repeat (HOLD_CYC - 1) tick();
        checkOutput("rom_ready before hold end", rom_ready, 0);
        tick();
        checkOutput("rom_ready after hold", rom_ready, 1);
        checkOutput("core_reset after hold", core_reset, 0);
    endtask

    // Linear sequence of directed tests.
    initial begin
        #2 reset_n = 1'b0;
        #1;
        checkOutput("T1 async core_reset", core_reset, 1);
        tick();
        tick();
        checkOutput("T1 dn_wr", dn_wr, 0);
        checkOutput("T1 core_reset", core_reset, 1);
        checkOutput("T1 rom_ready", rom_ready, 0);
        checkOutput("T1 rom_err", rom_err, 0);
        checkOutput("T1 byte_count", byte_count, 0);
        checkOutput("T1 checksum", checksum, 0);
        reset_n = 1'b1;
        tick();
        checkOutput("T1 idle core_reset", core_reset, 1);

        $display("[TB] T2 full image");
        sendRange(16'd0, 0, 15);
        checkOutput("T2 core_reset loading", core_reset, 1);
        finishDownload();
        checkOutput("T2 rom_err", rom_err, 0);
        checkOutput("T2 byte_count", byte_count, 16);
        checkOutput("T2 checksum", checksum, SUM_FULL);

        $display("[TB] T5 foreign index download");
        sendRange(16'd1, 0, 3);
        checkOutput("T5 rom_ready", rom_ready, 1);
        checkOutput("T5 core_reset", core_reset, 0);
        applyStimulus(1'b0, 1'b0, 25'd0, 8'd0, 16'd0);
        repeat (HOLD_CYC + 1) tick();
        checkOutput("T5 rom_ready later", rom_ready, 1);
        checkOutput("T5 byte_count", byte_count, 16);

        $display("[TB] T3 overflowing image");
        sendRange(16'd0, 0, 0);
        checkOutput("T3 rom_ready drops", rom_ready, 0);
        checkOutput("T3 core_reset rises", core_reset, 1);
        sendRange(16'd0, 1, 15);
        applyStimulus(1'b1, 1'b1, 25'd16, 8'hAA, 16'd0);
        checkOutput("T3 dn_wr addr16", dn_wr, 0);
        checkOutput("T3 rom_err immediate", rom_err, 1);
        finishDownload();
        checkOutput("T3 rom_err", rom_err, 1);
        checkOutput("T3 byte_count", byte_count, 16);
        checkOutput("T3 checksum", checksum, SUM_FULL);

        $display("[TB] T4 short image");
        sendRange(16'd0, 0, 0);
        checkOutput("T4 rom_err cleared on entry", rom_err, 0);
        checkOutput("T4 byte_count restart", byte_count, 1);
        sendRange(16'd0, 1, 7);
        finishDownload();
        checkOutput("T4 rom_err", rom_err, 1);
        checkOutput("T4 byte_count", byte_count, 8);
        checkOutput("T4 checksum", checksum, SUM_HALF);

        $display("[TB] T6 reset mid-download");
        sendRange(16'd0, 0, 4);
        checkOutput("T6 byte_count before reset", byte_count, 5);
        ioctl_wr = 1'b0;
        reset_n  = 1'b0;
        #1;
        checkOutput("T6 reset byte_count", byte_count, 0);
        checkOutput("T6 reset core_reset", core_reset, 1);
        checkOutput("T6 reset rom_ready", rom_ready, 0);
        tick();
        reset_n = 1'b1;
        sendRange(16'd0, 6, 15);
        checkOutput("T6 byte_count partial", byte_count, 10);
        finishDownload();
        checkOutput("T6 rom_err partial", rom_err, 1);
        checkOutput("T6 byte_count end", byte_count, 10);
        sendRange(16'd0, 0, 15);
        finishDownload();
        checkOutput("T6 rom_err resend", rom_err, 0);
        checkOutput("T6 byte_count resend", byte_count, 16);
        checkOutput("T6 checksum resend", checksum, SUM_FULL);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
